// File: rtl/alaw_stream_encoder.sv
// alaw_stream_encoder
//   Streaming G.711 A-law compressor. Two's-complement linear samples enter on
//   a valid/ready port, 8-bit A-law codes leave on a valid/ready port two
//   clocks later. A channel tag travels with every sample so that a single
//   instance can serve several time-multiplexed channels. Sustains one sample
//   per clock when the downstream side is always ready.
//
//   Stage 1 registers the sign and the 12-bit scaled magnitude of each
//   accepted sample. Stage 2 is the output register. It holds the segment and
//   mantissa code, optionally XORed with 8'h55 to give the line format.
//
// Ports
//   clk        in   1      clock, all state on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      input sample valid
//   in_ready   out  1      encoder can accept (combinational from out_ready)
//   in_data    in   IN_W   linear sample, two's complement
//   in_ch      in   CH_W   channel tag for in_data
//   out_valid  out  1      out_data/out_ch valid
//   out_ready  in   1      downstream accepts
//   out_data   out  8      A-law code
//   out_ch     out  CH_W   channel tag accepted with the sample
//   clip_clr   in   1      synchronous clear of clip_cnt (wins over increment)
//   clip_cnt   out  CNT_W  saturating count of accepted most-negative samples
module alaw_stream_encoder #(
    parameter int IN_W     = 16,
    parameter int CH_W     = 3,
    parameter int EVEN_INV = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_data,
    input  logic [CH_W-1:0]   in_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [CH_W-1:0]   out_ch,
    input  logic              clip_clr,
    output logic [CNT_W-1:0]  clip_cnt
);

    localparam logic [IN_W-1:0]  MOST_NEG = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic [IN_W-1:0]  MAX_POS  = {1'b0, {(IN_W-1){1'b1}}};
    localparam logic [IN_W-1:0]  ONE_IN   = {{(IN_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Sign/segment/mantissa code from the sign and the 12-bit magnitude.
    // Segments 0 and 1 both take the mantissa from m[4:1]; every higher
    // segment takes the four bits just below its leading one.
    function automatic logic [7:0] alaw_code(input logic sign, input logic [11:0] m);
        logic [2:0] seg;
        logic [3:0] mant;
        casez (m[11:5])
            7'b1??????: begin seg = 3'd7; mant = m[10:7]; end
            7'b01?????: begin seg = 3'd6; mant = m[9:6];  end
            7'b001????: begin seg = 3'd5; mant = m[8:5];  end
            7'b0001???: begin seg = 3'd4; mant = m[7:4];  end
            7'b00001??: begin seg = 3'd3; mant = m[6:3];  end
            7'b000001?: begin seg = 3'd2; mant = m[5:2];  end
            7'b0000001: begin seg = 3'd1; mant = m[4:1];  end
            default:    begin seg = 3'd0; mant = m[4:1];  end
        endcase
        return {~sign, seg, mant};
    endfunction

    logic              s2_rdy_s;
    logic              accept_s;
    logic              sign_s;
    logic              clip_s;
    logic [IN_W-1:0]   neg_s;
    logic [IN_W-1:0]   mag_s;
    logic [11:0]       m_s;
    logic [7:0]        code_s;
    logic [7:0]        line_code_s;

    logic              s1_valid_r;
    logic              s1_sign_r;
    logic [11:0]       s1_m_r;
    logic [CH_W-1:0]   s1_ch_r;

    // Handshake: a stage may load only when the stage after it is free or draining.
    always_comb begin
        s2_rdy_s = !out_valid || out_ready;
        in_ready = !s1_valid_r || s2_rdy_s;
        accept_s = in_valid && in_ready;
    end

    // Stage-1 datapath: sign, saturated magnitude, and its top 12 bits.
    always_comb begin
        sign_s = in_data[IN_W-1];
        neg_s  = ~in_data + ONE_IN;
        clip_s = (in_data == MOST_NEG);
        if (clip_s) begin
            mag_s = MAX_POS;
        end else if (sign_s) begin
            mag_s = neg_s;
        end else begin
            mag_s = in_data;
        end
        // The magnitude MSB is always 0 after saturation, so truncation is lossless.
        m_s = 12'(mag_s >> (IN_W - 13));
    end

    // Stage-2 datapath: A-law code and optional even-bit inversion.
    always_comb begin
        code_s = alaw_code(s1_sign_r, s1_m_r);
        if (EVEN_INV != 0) begin
            line_code_s = code_s ^ 8'h55;
        end else begin
            line_code_s = code_s;
        end
    end

    // Stage-1 register: capture on accept, empty once the output stage takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_sign_r  <= 1'b0;
            s1_m_r     <= 12'd0;
            s1_ch_r    <= {CH_W{1'b0}};
        end else begin
            if (in_ready) begin
                s1_valid_r <= in_valid;
            end
            if (accept_s) begin
                s1_sign_r <= sign_s;
                s1_m_r    <= m_s;
                s1_ch_r   <= in_ch;
            end
        end
    end

    // Output register: the code is held stable while the downstream side stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_ch    <= {CH_W{1'b0}};
        end else if (s2_rdy_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_data <= line_code_s;
                out_ch   <= s1_ch_r;
            end
        end
    end

    // Clip counter: the clear wins, and the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_cnt <= {CNT_W{1'b0}};
        end else if (clip_clr) begin
            clip_cnt <= {CNT_W{1'b0}};
        end else if (accept_s && clip_s && (clip_cnt != CNT_MAX)) begin
            clip_cnt <= clip_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_alaw_stream_encoder.sv
// tb_alaw_stream_encoder
//   Directed bench for alaw_stream_encoder (IN_W=16, EVEN_INV=1, small clip
//   counter so saturation is reachable). An arithmetic A-law model feeds an
//   expected-output queue. One negedge process compares every emitted code
//   and tag, plus in_ready, output stability under stall, and clip_cnt.
module tb_alaw_stream_encoder;

    localparam int IN_W  = 16;
    localparam int CH_W  = 3;
    localparam int CNT_W = 4;
    localparam int CNT_SAT = 15;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic [CH_W-1:0]   in_ch;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [CH_W-1:0]   out_ch;
    logic              clip_clr;
    logic [CNT_W-1:0]  clip_cnt;

    int checks;
    int failures;
    int pops;
    int clip_model;
    bit prev_hold;
    logic [7:0]      prev_data;
    logic [CH_W-1:0] prev_ch;
    logic [10:0]     exp_q[$];
    bit bp_done;

    alaw_stream_encoder #(
        .IN_W(IN_W), .CH_W(CH_W), .EVEN_INV(1), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ch(out_ch),
        .clip_clr(clip_clr), .clip_cnt(clip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // G.711 A-law from plain integer arithmetic.
    function automatic logic [7:0] model_alaw(input int x, input bit inv);
        int mag, m, seg, mant, p, code;
        mag = (x < 0) ? -x : x;
        if (mag > 32767) mag = 32767;
        m = mag / 8;
        if (m < 32) begin
            seg  = 0;
            mant = (m / 2) % 16;
        end else begin
            p = 11;
            while ((m >> p) == 0) p--;
            seg  = p - 4;
            mant = (m >> (p - 4)) % 16;
        end
        code = ((x < 0) ? 0 : 128) + seg * 16 + mant;
        if (inv) code = code ^ 32'h55;
        return code[7:0];
    endfunction

    // Compare process: scoreboard, in_ready model, stall stability, clip counter.
    always @(negedge clk) begin
        logic [10:0] e;
        if (!rst_n) begin
            exp_q.delete();
            clip_model = 0;
            prev_hold  = 1'b0;
        end else begin
            check("clip_cnt", 32'(clip_cnt), 32'(clip_model));
            check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
            if (prev_hold) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(prev_data));
                check("hold_ch", 32'(out_ch), 32'(prev_ch));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    pops++;
                    check("out_data", 32'(out_data), 32'(e[10:3]));
                    check("out_ch", 32'(out_ch), 32'(e[2:0]));
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_ch   = out_ch;
            if (in_valid && in_ready) begin
                exp_q.push_back({model_alaw(int'($signed(in_data)), 1'b1), in_ch});
            end
            if (clip_clr) begin
                clip_model = 0;
            end else if (in_valid && in_ready && in_data == 16'h8000 && clip_model < CNT_SAT) begin
                clip_model++;
            end
        end
    end

    // Present one sample and return at posedge+1 after it is accepted.
    task automatic send(input logic [15:0] d, input logic [2:0] c, input logic clr);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_ch    = c;
        clip_clr = clr;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clip_clr = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic single(input logic [15:0] d, input logic [7:0] lit);
        send(d, 3'd5, 1'b0);
        @(negedge clk);
        check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        check("single_code", 32'(out_data), 32'(lit));
        check("single_ch", 32'(out_ch), 32'd5);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0, run;
        checks = 0; failures = 0; pops = 0; bp_done = 1'b0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 16'h0000; in_ch = 3'd0;
        out_ready = 1'b1; clip_clr = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_clip_cnt", 32'(clip_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Hand-computed values pinning the model.
        check("pin_0", 32'(model_alaw(0, 1'b1)), 32'hD5);
        check("pin_m8", 32'(model_alaw(-8, 1'b1)), 32'h55);
        check("pin_1024", 32'(model_alaw(1024, 1'b1)), 32'hE5);
        check("pin_32767", 32'(model_alaw(32767, 1'b1)), 32'hAA);
        check("pin_m32768", 32'(model_alaw(-32768, 1'b1)), 32'h2A);
        check("pin_raw248", 32'(model_alaw(248, 1'b0)), 32'h8F);
        check("pin_raw255", 32'(model_alaw(255, 1'b0)), 32'h8F);
        check("pin_raw256", 32'(model_alaw(256, 1'b0)), 32'h90);

        // Single samples with latency.
        single(16'h0000, 8'hD5);
        single(16'hFFF8, 8'h55);
        single(16'h0400, 8'hE5);
        single(16'h7FFF, 8'hAA);
        single(16'h8000, 8'h2A);
        check("clip_after_one", 32'(clip_cnt), 32'd1);

        // Clear takes priority over a simultaneous clipped accept.
        send(16'h8000, 3'd1, 1'b1);
        check("clip_clr_priority", 32'(clip_cnt), 32'd0);
        drain();

        // Saturation of the counter.
        for (int i = 0; i < 20; i++) send(16'h8000, 3'(i), 1'b0);
        check("clip_saturate", 32'(clip_cnt), 32'(CNT_SAT));
        send(16'h0010, 3'd0, 1'b1);
        check("clip_clr_plain", 32'(clip_cnt), 32'd0);
        drain();

        // Segment edges.
        send(16'd248, 3'd2, 1'b0);
        send(16'd255, 3'd3, 1'b0);
        send(16'd256, 3'd4, 1'b0);
        drain();

        // Eight samples with out_ready low for clocks 3-6.
        p0 = pops;
        fork
            begin
                for (int i = 0; i < 8; i++) send(16'(i * 1000 - 3000), 3'(i), 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("stall_in_ready_low", 32'(in_ready), 32'd0);
                check("stall_out_valid", 32'(out_valid), 32'd1);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stall_count", 32'(pops - p0), 32'd8);

        // Rotating channels at full throughput.
        fork
            begin
                for (int i = 0; i < 16; i++) send(16'(i * 300 - 2000), 3'(i % 8), 1'b0);
            end
            begin
                run = 0;
                @(negedge clk);
                for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
                while (out_valid && run < 40) begin
                    run++;
                    @(negedge clk);
                end
                check("throughput_run", 32'(run), 32'd16);
            end
        join
        drain();

        // Sweep every m value, alternating sign.
        for (int m = 0; m < 4096; m++) begin
            int x;
            x = m * 8 + (m % 8);
            if (m % 2 == 1) x = -x;
            send(16'(x), 3'(m), 1'b0);
        end
        drain();

        // Random backpressure.
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++)
                    send(16'($urandom_range(0, 65535)), 3'($urandom_range(0, 7)), 1'b0);
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two samples in flight.
        send(16'd100, 3'd1, 1'b0);
        send(16'd200, 3'd2, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_drop", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("rst_no_stale", 32'(out_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
